stage_round_robin_scheduler: RTL and testbench

Round-robin scheduler that shares one factorial datapath resource, such as the multiplier stage, among seven requesters. It produces a registered 3-bit grant code `sel` plus a qualifying `valid`. `sel` drives the existing 3-to-7 one-hot decoder, and the decoder output becomes the per-requester enable. Each grant ends on a resource `done`, on the requester withdrawing, or (optionally) on a hold timeout, followed by a one-cycle bus gap.

---
 rtl/stage_round_robin_scheduler_if.sv | 29 ++
 rtl/stage_round_robin_scheduler.sv | 135 +++++++++++++
 tb/tb_stage_round_robin_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/stage_round_robin_scheduler_if.sv
// Grant bus between the seven requesters and the shared-datapath scheduler.
// The master side is the scheduler; the slave side is the requester/resource pool.
// Timeout build option (SCHED_TIMEOUT_EN) does not change this bundle.
interface stage_round_robin_scheduler_if;
   logic [6:0] req;
   logic       done;
   logic [2:0] sel;
   logic       valid;
   logic       timeout;
   logic       idle;

   modport master (
      input  req,
      input  done,
      output sel,
      output valid,
      output timeout,
      output idle
   );

   modport slave (
      output req,
      output done,
      input  sel,
      input  valid,
      input  timeout,
      input  idle
   );
endinterface

// File: rtl/stage_round_robin_scheduler.sv
// Purpose: round-robin grant of one shared datapath stage among 7 requesters (sel + valid).
// Latency: grant registered one edge after req seen in IDLE; release + GAP + IDLE = 2 dead cycles.
// Backpressure: requesters hold req until served; grant ends on done, req drop, or hold timeout (SCHED_TIMEOUT_EN).
module stage_round_robin_scheduler #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   stage_round_robin_scheduler_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     state, state_nx;
   logic [2:0] sel_q, sel_nx;
   logic [2:0] last_q, last_nx;
   logic       valid_q, valid_nx;
   logic       timeout_q, timeout_nx;
   logic [2:0] winner;
   logic       rel_done;
   logic       rel_hold;

   if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CNT_W) - 1) begin : g_bad_hold
      $error("HOLD_MAX does not fit the hold counter width");
   end

   // First set request at last+1, last+2, ... modulo 7.
   function automatic logic [2:0] pick_next(input logic [6:0] r, input logic [2:0] l);
      logic [2:0] w;
      logic       found;
      w     = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         int idx;
         idx = (int'(l) + k) % 7;
         if (!found && r[idx]) begin
            w     = 3'(idx);
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign winner   = pick_next(bus.req, last_q);
   assign rel_done = bus.done | ~bus.req[sel_q];

`ifdef SCHED_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   assign rel_hold = (cnt_q == CNT_W'(HOLD_MAX - 1));

   // Hold counter: cycles the current grant has stayed live beyond its first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_nx;
   end
`else
   assign rel_hold = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Registered grant outputs and the round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q     <= 3'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         last_q    <= 3'd6;
      end else begin
         sel_q     <= sel_nx;
         valid_q   <= valid_nx;
         timeout_q <= timeout_nx;
         last_q    <= last_nx;
      end
   end

   // Next-state and next-output decode; sel only moves when a new grant is issued.
   always_comb begin
      state_nx   = state;
      sel_nx     = sel_q;
      valid_nx   = valid_q;
      timeout_nx = 1'b0;
      last_nx    = last_q;
`ifdef SCHED_TIMEOUT_EN
      cnt_nx     = cnt_q;
`endif
      case (state)
         IDLE: begin
            if (|bus.req) begin
               sel_nx   = winner;
               valid_nx = 1'b1;
               state_nx = GRANT;
`ifdef SCHED_TIMEOUT_EN
               cnt_nx   = '0;
`endif
            end
         end
         GRANT: begin
            if (rel_done || rel_hold) begin
               valid_nx   = 1'b0;
               last_nx    = sel_q;
               timeout_nx = rel_hold & ~rel_done;
               state_nx   = GAP;
            end else begin
`ifdef SCHED_TIMEOUT_EN
               cnt_nx = cnt_q + 1'b1;
`endif
            end
         end
         GAP: begin
            valid_nx = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            valid_nx = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.sel     = sel_q;
   assign bus.valid   = valid_q;
   assign bus.timeout = timeout_q;
   assign bus.idle    = (state == IDLE);

endmodule

// File: tb/tb_stage_round_robin_scheduler.sv
// Bench for the round-robin scheduler: directed scenarios plus randomized traffic.
// A cycle-level reference model of the arbitration rules is compared against the DUT every cycle.
// Timeout scenarios follow the SCHED_TIMEOUT_EN build option.
module tb_stage_round_robin_scheduler;
   localparam int HOLD_MAX = 15;
   localparam int CNT_W    = 4;
`ifdef SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   stage_round_robin_scheduler_if bus();

   stage_round_robin_scheduler #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner of the bus, dead cycles pending, cycles the grant has been live.
   int m_owner, m_gap, m_high, m_last;
   int m_sel, m_valid, m_timeout;

   task automatic m_reset();
      m_owner = -1; m_gap = 0; m_high = 0; m_last = 6;
      m_sel = 0; m_valid = 0; m_timeout = 0;
   endtask

   task automatic m_step(input logic [6:0] r, input logic d);
      m_timeout = 0;
      if (m_owner >= 0) begin
         bit by_drop, by_hold;
         by_drop = !r[m_owner];
         by_hold = TO_EN && (m_high == HOLD_MAX);
         if (d || by_drop || by_hold) begin
            m_timeout = (by_hold && !d && !by_drop) ? 1 : 0;
            m_last    = m_owner;
            m_owner   = -1;
            m_valid   = 0;
            m_gap     = 2;
         end else begin
            m_high++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 1) m_gap = 0;
      end else if (r != 7'd0) begin
         int w;
         w = -1;
         for (int k = 1; k <= 7; k++)
            if (w < 0 && r[(m_last + k) % 7]) w = (m_last + k) % 7;
         m_owner = w; m_sel = w; m_valid = 1; m_high = 1;
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_reset();
      else          m_step(bus.req, bus.done);
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      chk("cyc_sel", int'(bus.sel), m_sel);
      chk("cyc_valid", int'(bus.valid), m_valid);
      chk("cyc_timeout", int'(bus.timeout), m_timeout);
      chk("cyc_idle", int'(bus.idle), (m_owner < 0 && m_gap == 0) ? 1 : 0);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_grant(output int g, output int n);
      n = 0;
      while (!bus.valid && n < 50) begin
         step();
         n++;
      end
      if (!bus.valid) chk("grant_wait_budget", 0, 1);
      g = bus.valid ? int'(bus.sel) : -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int g, n, seen_to;
      int rr_exp [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
      bus.req  = 7'h7F;
      bus.done = 1'b0;
      reset_n  = 1'b0;
      repeat (3) step();
      chk("rst_sel", int'(bus.sel), 0);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_idle", int'(bus.idle), 1);
      chk("rst_timeout", int'(bus.timeout), 0);
      reset_n = 1'b1;
      wait_grant(g, n);
      chk("rr_order", g, rr_exp[0]);

      // Full request vector, done one cycle into each grant.
      for (int i = 1; i < 8; i++) begin
         bus.done = 1'b1; step(); bus.done = 1'b0;
         chk("rr_pulse_len", int'(bus.valid), 0);
         wait_grant(g, n);
         chk("rr_order", g, rr_exp[i]);
         chk("rr_gap_cycles", n, 2);
      end

      // Sparse requests: bring last to 1, then 6 wins before 1.
      bus.req = 7'b0000010; bus.done = 1'b1; step(); bus.done = 1'b0;
      wait_grant(g, n);
      chk("sparse_first", g, 1);
      bus.req = 7'b1000010; bus.done = 1'b1; step(); bus.done = 1'b0;
      wait_grant(g, n);
      chk("sparse_six", g, 6);
      repeat (3) step();
      chk("sparse_hold_valid", int'(bus.valid), 1);
      chk("sparse_hold_sel", int'(bus.sel), 6);
      bus.req = 7'b0000010; step();
      chk("drop_valid", int'(bus.valid), 0);
      chk("drop_timeout", int'(bus.timeout), 0);
      wait_grant(g, n);
      chk("sparse_then_one", g, 1);
      bus.done = 1'b1; step(); bus.done = 1'b0;
      bus.req = 7'd0;
      repeat (3) step();

      // Single requester that never signals done.
      bus.req = 7'b0001000;
      wait_grant(g, n);
      chk("to_grant", g, 3);
`ifdef SCHED_TIMEOUT_EN
      n = 0;
      while (bus.valid && n < 100) begin step(); n++; end
      chk("to_high_cycles", n, HOLD_MAX);
      chk("to_pulse", int'(bus.timeout), 1);
      step();
      chk("to_pulse_len", int'(bus.timeout), 0);
      chk("to_gap_valid", int'(bus.valid), 0);
      wait_grant(g, n);
      chk("to_regrant", g, 3);
      chk("to_regrant_wait", n, 1);
      repeat (HOLD_MAX - 1) step();
      chk("coll_still_valid", int'(bus.valid), 1);
      bus.done = 1'b1; step(); bus.done = 1'b0;
      chk("coll_valid", int'(bus.valid), 0);
      chk("coll_no_timeout", int'(bus.timeout), 0);
`else
      n = 0; seen_to = 0;
      repeat (40) begin
         step();
         if (bus.valid) n++;
         if (bus.timeout) seen_to++;
      end
      chk("hold_forever", n, 40);
      chk("never_timeout", seen_to, 0);
      bus.done = 1'b1; step(); bus.done = 1'b0;
      chk("hold_release", int'(bus.valid), 0);
`endif
      bus.req = 7'd0;
      repeat (3) step();

      // Asynchronous reset between edges during a live grant.
      bus.req = 7'b0001000;
      wait_grant(g, n);
      chk("ar_grant", g, 3);
      bus.req = 7'h7F;
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_valid", int'(bus.valid), 0);
      chk("ar_idle", int'(bus.idle), 1);
      chk("ar_sel", int'(bus.sel), 0);
      step(); step();
      reset_n = 1'b1;
      wait_grant(g, n);
      chk("ar_restart", g, 0);
      bus.done = 1'b1; step(); bus.done = 1'b0;

      // Randomized traffic; later phase makes done rare so holds run long.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 7'($urandom);
         if (i < 1500) bus.done = ($urandom_range(0, 3) == 0);
         else          bus.done = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
